// File: rtl/fp16_norm_round_if.sv
// Bundle of the upstream product port and the downstream result port of fp16_norm_round.
// Handshake: a transfer happens on a clock edge where valid & ready are both high; once raised,
// valid and its payload hold until that transfer, and ready may depend combinationally on state.
interface fp16_norm_round_if #(
  parameter int EXP_W = 5,
  parameter int MAN_W = 10
);
  logic                     io_in_valid;
  logic                     io_in_ready;
  logic                     io_in_sign;
  logic [EXP_W:0]           io_in_exp_sum;
  logic [2*(MAN_W+1)-1:0]   io_in_prod;
  logic                     io_in_zero;
  logic                     io_in_inf;
  logic                     io_in_nan;
  logic                     io_out_valid;
  logic                     io_out_ready;
  logic [EXP_W+MAN_W:0]     io_out_bits;
  logic [2:0]               io_out_flags;

  modport master (
    output io_in_valid, io_in_sign, io_in_exp_sum, io_in_prod,
           io_in_zero, io_in_inf, io_in_nan, io_out_ready,
    input  io_in_ready, io_out_valid, io_out_bits, io_out_flags
  );

  modport slave (
    input  io_in_valid, io_in_sign, io_in_exp_sum, io_in_prod,
           io_in_zero, io_in_inf, io_in_nan, io_out_ready,
    output io_in_ready, io_out_valid, io_out_bits, io_out_flags
  );
endinterface

// File: rtl/fp16_norm_round.sv
// Normalise / round-to-nearest-even / pack stage for the binary16 multiplier.
// Two registered stages with valid/ready; results are produced in order, 2 cycles after accept.
module fp16_norm_round #(
  parameter int EXP_W = 5,
  parameter int MAN_W = 10
) (
  input  logic              clock,
  input  logic              reset,
  fp16_norm_round_if.slave  io
);
  localparam int BIAS = (1 << (EXP_W - 1)) - 1;
  localparam int PW   = 2 * (MAN_W + 1);
  localparam int EW   = EXP_W + 3;
  localparam int OW   = 1 + EXP_W + MAN_W;
  localparam logic signed [EW-1:0] E_MAX = EW'((1 << EXP_W) - 1);
  localparam logic signed [EW-1:0] E_MIN = '0;

  // stage 1 registers
  logic                    s1_valid;
  logic                    s1_sign;
  logic signed [EW-1:0]    s1_e;
  logic [MAN_W-1:0]        s1_m;
  logic                    s1_inc;
  logic                    s1_gs;
  logic                    s1_zero;
  logic                    s1_inf;
  logic                    s1_nan;

  // stage 2 registers
  logic                    s2_valid;
  logic [OW-1:0]           s2_bits;
  logic [2:0]              s2_flags;

  logic s1_ready;
  logic s2_ready;

  assign s2_ready        = !s2_valid || io.io_out_ready;
  assign s1_ready        = !s1_valid || s2_ready;
  assign io.io_in_ready  = s1_ready;
  assign io.io_out_valid = s2_valid;
  assign io.io_out_bits  = s2_bits;
  assign io.io_out_flags = s2_flags;

  // Normalise: the product of two 1.x significands lies in [1,4), so at most one right shift.
  logic                 n_top;
  logic [MAN_W-1:0]     n_m;
  logic                 n_g;
  logic                 n_s;
  logic signed [EW-1:0] n_e;

  always_comb begin
    n_top = io.io_in_prod[PW-1];
    n_m   = '0;
    n_g   = 1'b0;
    n_s   = 1'b0;
    if (n_top) begin
      n_m = io.io_in_prod[PW-2 -: MAN_W];
      n_g = io.io_in_prod[PW-2-MAN_W];
      n_s = |io.io_in_prod[PW-3-MAN_W:0];
    end else begin
      n_m = io.io_in_prod[PW-3 -: MAN_W];
      n_g = io.io_in_prod[PW-3-MAN_W];
      n_s = |io.io_in_prod[PW-4-MAN_W:0];
    end
    n_e = EW'(io.io_in_exp_sum) - EW'(BIAS) + EW'(n_top);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_sign  <= 1'b0;
      s1_e     <= '0;
      s1_m     <= '0;
      s1_inc   <= 1'b0;
      s1_gs    <= 1'b0;
      s1_zero  <= 1'b0;
      s1_inf   <= 1'b0;
      s1_nan   <= 1'b0;
    end else if (s1_ready) begin
      s1_valid <= io.io_in_valid;
      if (io.io_in_valid) begin
        s1_sign <= io.io_in_sign;
        s1_e    <= n_e;
        s1_m    <= n_m;
        s1_inc  <= n_g & (n_s | n_m[0]);
        s1_gs   <= n_g | n_s;
        s1_zero <= io.io_in_zero;
        s1_inf  <= io.io_in_inf;
        s1_nan  <= io.io_in_nan;
      end
    end
  end

  // Round and pack; a mantissa carry-out bumps the exponent before the range checks.
  logic [MAN_W:0]       r_m;
  logic signed [EW-1:0] r_e;
  logic [OW-1:0]        p_bits;
  logic [2:0]           p_flags;

  always_comb begin
    r_m     = {1'b0, s1_m} + (MAN_W + 1)'(s1_inc);
    r_e     = s1_e + EW'(r_m[MAN_W]);
    p_bits  = '0;
    p_flags = 3'b000;
    if (s1_nan) begin
      p_bits = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
    end else if (s1_inf) begin
      p_bits = {s1_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (s1_zero) begin
      p_bits = {s1_sign, {(EXP_W+MAN_W){1'b0}}};
    end else if (r_e >= E_MAX) begin
      p_bits  = {s1_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      p_flags = 3'b101;
    end else if (r_e <= E_MIN) begin
      p_bits  = {s1_sign, {(EXP_W+MAN_W){1'b0}}};
      p_flags = 3'b011;
    end else begin
      p_bits  = {s1_sign, r_e[EXP_W-1:0], r_m[MAN_W-1:0]};
      p_flags = {2'b00, s1_gs};
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s2_valid <= 1'b0;
      s2_bits  <= '0;
      s2_flags <= 3'b000;
    end else if (s2_ready) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_bits  <= p_bits;
        s2_flags <= p_flags;
      end
    end
  end
endmodule

// File: tb/tb_fp16_norm_round.sv
// Bench for fp16_norm_round: directed test-plan vectors, backpressure, mid-stream reset,
// then randomized traffic against an arithmetic reference model via an expected-value queue.
module tb_fp16_norm_round;
  logic clock;
  logic reset;
  int   total;
  int   bad;
  int   out_count;
  bit   rand_ready;
  logic [18:0] exp_q[$];

  fp16_norm_round_if io ();

  fp16_norm_round dut (
    .clock (clock),
    .reset (reset),
    .io    (io)
  );

  // clock / reset
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference: round the exact product value to 11 significant bits, nearest-even.
  function automatic logic [18:0] model(input logic sign, input int exp_sum, input int prod,
                                        input logic z, input logic i, input logic n);
    int shift, q, rem, half, e;
    logic inexact;
    if (n) return {3'b000, 16'h7E00};
    if (i) return {3'b000, sign, 15'h7C00};
    if (z) return {3'b000, sign, 15'h0000};
    shift = (prod >= (1 << 21)) ? 11 : 10;
    q     = prod >> shift;
    rem   = prod - (q << shift);
    half  = 1 << (shift - 1);
    inexact = (rem != 0);
    if (rem > half || (rem == half && (q % 2) == 1)) q++;
    e = exp_sum - 15 + (shift - 10);
    if (q >= 2048) begin
      q = q / 2;
      e++;
    end
    if (e >= 31) return {3'b101, sign, 15'h7C00};
    if (e <= 0)  return {3'b011, sign, 15'h0000};
    return {2'b00, inexact, sign, 5'(e), 10'(q - 1024)};
  endfunction

  // scoreboard: sampled on the falling edge, i.e. the transfers of the coming rising edge
  always @(negedge clock) begin
    if (!reset) begin
      if (io.io_out_valid && io.io_out_ready) begin
        out_count++;
        if (exp_q.size() == 0) check("extra_output", 1, 0);
        else check("scoreboard", {13'd0, io.io_out_flags, io.io_out_bits}, {13'd0, exp_q.pop_front()});
      end
      if (io.io_in_valid && io.io_in_ready)
        exp_q.push_back(model(io.io_in_sign, int'(io.io_in_exp_sum), int'(io.io_in_prod),
                              io.io_in_zero, io.io_in_inf, io.io_in_nan));
    end
  end

  initial begin
    forever begin
      @(posedge clock);
      #1;
      if (rand_ready) io.io_out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // driver tasks
  task automatic present(input logic sg, input logic [5:0] es, input logic [21:0] pr,
                         input logic z, input logic i, input logic n);
    io.io_in_valid   = 1'b1;
    io.io_in_sign    = sg;
    io.io_in_exp_sum = es;
    io.io_in_prod    = pr;
    io.io_in_zero    = z;
    io.io_in_inf     = i;
    io.io_in_nan     = n;
  endtask

  task automatic idle();
    io.io_in_valid = 1'b0;
  endtask

  task automatic send(input logic sg, input logic [5:0] es, input logic [21:0] pr,
                      input logic z, input logic i, input logic n);
    int waited;
    waited = 0;
    present(sg, es, pr, z, i, n);
    forever begin
      @(negedge clock);
      if (io.io_in_ready) break;
      waited++;
      if (waited > 200) begin
        check("send_timeout", 0, 1);
        break;
      end
    end
    @(posedge clock);
    #1;
  endtask

  task automatic run_one(input string tag, input logic sg, input logic [5:0] es,
                         input logic [21:0] pr, input logic z, input logic i, input logic n,
                         input logic [15:0] exp_bits, input logic [2:0] exp_flags);
    int lat;
    send(sg, es, pr, z, i, n);
    idle();
    lat = 1;
    while (!io.io_out_valid && lat < 20) begin
      @(posedge clock);
      #1;
      lat++;
    end
    check({tag, "_latency"}, lat, 2);
    check({tag, "_bits"}, io.io_out_bits, exp_bits);
    check({tag, "_flags"}, io.io_out_flags, exp_flags);
    @(posedge clock);
    #1;
  endtask

  logic [21:0] bp_prod[4];
  logic [18:0] held;
  int k, start_out;
  bit acc;

  initial begin
    total = 0;
    bad = 0;
    out_count = 0;
    rand_ready = 0;
    io.io_out_ready = 1'b1;
    io.io_in_valid = 1'b0;
    present(1'b0, 6'd0, 22'h100000, 1'b0, 1'b0, 1'b0);
    idle();
    reset = 1'b1;
    #17;
    check("reset_out_valid", io.io_out_valid, 0);
    check("reset_out_bits", io.io_out_bits, 16'h0000);
    check("reset_out_flags", io.io_out_flags, 3'b000);
    check("reset_in_ready", io.io_in_ready, 1);
    @(posedge clock);
    #1;
    reset = 1'b0;
    @(posedge clock);
    #1;

    // directed test-plan vectors
    run_one("one_x_one", 0, 6'd30, 22'h100000, 0, 0, 0, 16'h3C00, 3'b000);
    run_one("onehalf_sq", 0, 6'd30, 22'h240000, 0, 0, 0, 16'h4080, 3'b000);
    run_one("tie_even", 0, 6'd30, 22'h100200, 0, 0, 0, 16'h3C00, 3'b001);
    run_one("tie_odd", 0, 6'd30, 22'h100600, 0, 0, 0, 16'h3C02, 3'b001);
    run_one("mant_carry", 0, 6'd30, 22'h3FFFFF, 0, 0, 0, 16'h4400, 3'b001);
    run_one("overflow", 0, 6'd50, 22'h100000, 0, 0, 0, 16'h7C00, 3'b101);
    run_one("underflow", 1, 6'd10, 22'h100000, 0, 0, 0, 16'h8000, 3'b011);
    run_one("nan", 1, 6'd30, 22'h100000, 0, 0, 1, 16'h7E00, 3'b000);
    run_one("inf", 1, 6'd30, 22'h100000, 0, 1, 0, 16'hFC00, 3'b000);
    run_one("zero", 1, 6'd30, 22'h100000, 1, 0, 0, 16'h8000, 3'b000);
    run_one("exp_edge_hi", 0, 6'd45, 22'h100000, 0, 0, 0, 16'h7800, 3'b000);
    run_one("exp_edge_lo", 0, 6'd16, 22'h100000, 0, 0, 0, 16'h0400, 3'b000);

    // backpressure: 4 back-to-back inputs with the sink stalled
    bp_prod[0] = 22'h100000;
    bp_prod[1] = 22'h240000;
    bp_prod[2] = 22'h100600;
    bp_prod[3] = 22'h3FFFFF;
    start_out = out_count;
    io.io_out_ready = 1'b0;
    k = 0;
    present(0, 6'd30, bp_prod[0], 0, 0, 0);
    for (int c = 0; c < 6; c++) begin
      @(negedge clock);
      acc = io.io_in_ready;
      @(posedge clock);
      #1;
      if (acc) begin
        k++;
        if (k < 4) present(0, 6'd30, bp_prod[k], 0, 0, 0);
      end
    end
    check("bp_accepted", k, 2);
    check("bp_in_ready_low", io.io_in_ready, 0);
    check("bp_out_valid", io.io_out_valid, 1);
    held = {io.io_out_flags, io.io_out_bits};
    check("bp_held_first", held, {3'b000, 16'h3C00});
    for (int c = 0; c < 3; c++) begin
      @(posedge clock);
      #1;
      check("bp_stable", {io.io_out_flags, io.io_out_bits}, held);
    end
    io.io_out_ready = 1'b1;
    for (int c = 0; c < 20 && k < 4; c++) begin
      @(negedge clock);
      acc = io.io_in_ready;
      @(posedge clock);
      #1;
      if (acc) begin
        k++;
        if (k < 4) present(0, 6'd30, bp_prod[k], 0, 0, 0);
      end
    end
    idle();
    repeat (5) @(posedge clock);
    #1;
    check("bp_out_count", out_count - start_out, 4);
    check("bp_queue_empty", exp_q.size(), 0);

    // reset with both stages full
    io.io_out_ready = 1'b0;
    send(1, 6'd31, 22'h180000, 0, 0, 0);
    send(0, 6'd29, 22'h2A0000, 0, 0, 0);
    idle();
    check("pre_reset_full", {io.io_out_valid, io.io_in_ready}, 2'b10);
    @(negedge clock);
    #2;
    reset = 1'b1;
    #1;
    check("async_reset_valid", io.io_out_valid, 0);
    check("async_reset_bits", io.io_out_bits, 16'h0000);
    exp_q.delete();
    @(posedge clock);
    #1;
    reset = 1'b0;
    io.io_out_ready = 1'b1;
    run_one("post_reset", 0, 6'd30, 22'h100000, 0, 0, 0, 16'h3C00, 3'b000);

    // randomized traffic with random sink stalls
    rand_ready = 1;
    for (int n = 0; n < 400; n++) begin
      logic [2:0] sp;
      sp = 3'(($urandom_range(0, 19) == 0) ? $urandom_range(1, 7) : 0);
      send(1'($urandom_range(0, 1)), 6'($urandom_range(0, 62)),
           22'($urandom_range(22'h100000, 22'h3FFFFF)), sp[0], sp[1], sp[2]);
      if ($urandom_range(0, 3) == 0) begin
        idle();
        repeat ($urandom_range(1, 2)) @(posedge clock);
        #1;
      end
    end
    idle();
    rand_ready = 0;
    io.io_out_ready = 1'b1;
    for (int c = 0; c < 50 && exp_q.size() != 0; c++) begin
      @(posedge clock);
      #1;
    end
    check("final_drain", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fp16_norm_round.md
Name: fp16_norm_round

Overview:
- Downstream stage of the half-precision multiplier datapath.
- Consumes the raw sign, exponent sum and full 22-bit significand product (hidden bits included) from the multiply stage. Normalises, rounds to nearest-even, handles exceptions and packs an IEEE-754 binary16 result.
- Two-stage valid/ready pipeline; replaces the truncate-and-concatenate packing of the raw multiplier.

Parameters:
- EXP_W, 5, exponent field width; BIAS = 2^(EXP_W-1)-1 = 15 is derived, not overridable.
- MAN_W, 10, stored mantissa width; product width is 2*(MAN_W+1) = 22.
- Only the defaults are verified.

Ports:
- clock  input  1  sole clock
- reset  input  1  asynchronous, active-high
- io_in_valid  input  1  upstream product valid
- io_in_ready  output  1  stage can accept
- io_in_sign  input  1  sign_a XOR sign_b
- io_in_exp_sum  input  EXP_W+1 (6)  biased exp_a + biased exp_b, 0..62
- io_in_prod  input  22  (1.ma)*(1.mb) as integer, range [2^20, 2^22)
- io_in_zero  input  1  an operand is zero or subnormal (flushed)
- io_in_inf  input  1  an operand is infinity
- io_in_nan  input  1  an operand is NaN, or inf*zero
- io_out_valid  output  1  result valid
- io_out_ready  input  1  downstream accepts
- io_out_bits  output  16  packed binary16 result
- io_out_flags  output  3  {overflow, underflow, inexact}

Behaviour:
- Reset: clock and reset are named as above; reset is asynchronous and active-high. On reset, s1_valid, s2_valid and io_out_valid go to 0, io_out_bits to 0x0000, and io_out_flags to 0. Reset mid-operation discards all in-flight data.
- Handshake:
  - s2_ready = !s2_valid | io_out_ready.
  - s1_ready = !s1_valid | s2_ready.
  - io_in_ready = s1_ready (combinational).
  - Transfers occur on valid & ready.
- Latency: 2 cycles from input accept to io_out_valid with no stall. Full throughput is 1 per cycle.
- io_out_bits and io_out_flags hold stable while io_out_valid & !io_out_ready. The pipeline never drops or reorders results.
- Stage 1 (normalise), registered:
  - If prod[21]=1: m = prod[20:11], g = prod[10], s = |prod[9:0], e = exp_sum - 15 + 1.
  - Else: m = prod[19:10], g = prod[9], s = |prod[8:0], e = exp_sum - 15.
  - e is held signed in EXP_W+3 (8) bits; inc = g & (s | m[0]).
  - Special flags, sign and (g|s) are registered alongside.
- Stage 2 (round/pack), registered output:
  - m' = m + inc. If m was all ones and inc=1, then m' = 0 and e = e + 1.
  - Then, in priority order:
    - nan -> 0x7E00 (sign forced 0), flags 000.
    - inf -> {sign, 0x7C00}, flags 000.
    - zero -> {sign, 0x0000}, flags 000.
    - e >= 31 -> {sign, 0x7C00}, overflow=1, inexact=1.
    - e <= 0 -> {sign, 0x0000} (flush, no subnormals), underflow=1, inexact=1.
    - otherwise -> {sign, e[4:0], m'}, inexact = g|s.
- io_in_prod is ignored when any special flag is set. Its range is guaranteed by upstream for normal operands and is not checked.
- Simultaneous accept and emit in the same cycle is legal whenever both stages are full and io_out_ready=1.

Test Plan:
- 1.0*1.0: exp_sum=30, prod=0x100000 -> 0x3C00, flags 000, io_out_valid exactly 2 cycles after accept.
- 1.5*1.5: exp_sum=30, prod=0x240000 -> 0x4080, flags 000.
- Round-to-nearest-even:
  - prod=0x100200 (tie, lsb 0) -> 0x3C00 with inexact=1.
  - prod=0x100600 (tie, lsb 1) -> 0x3C02 with inexact=1.
  - prod=0x3FFFFF, exp_sum=30 -> mantissa carry gives 0x4400, inexact=1.
- Range and specials:
  - sign=0, exp_sum=50, prod=0x100000 -> 0x7C00, flags 101.
  - sign=1, exp_sum=10 -> 0x8000, flags 011.
  - nan=1 -> 0x7E00.
  - inf=1, sign=1 -> 0xFC00.
  - zero=1, sign=1 -> 0x8000.
- Backpressure: hold io_out_ready=0 while driving 4 back-to-back valid inputs.
  - Exactly 2 are accepted, then io_in_ready=0.
  - io_out_bits stays stable.
  - Releasing io_out_ready yields all results in order, with no loss or duplication.
- Reset mid-stream: assert reset asynchronously between clock edges with both stages full.
  - io_out_valid drops to 0 immediately.
  - After release, the first new input emerges 2 cycles after accept with a correct value.
